// File: rtl/anomaly_reinsert.sv
// anomaly_reinsert: rebuilds anomaly pixels from original + difference-coded stream.
// Two-entry output buffer, raster position tracking and per-frame anomaly count.
module anomaly_reinsert #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int PIX_W = 8,
    parameter int CNT_W = $clog2(IMG_W*IMG_H+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] original_pixel,
    input  logic [PIX_W-1:0] modified_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_anomaly,
    output logic             m_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_anomalies
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             anom;
        logic             last;
    } ent_t;

    ent_t             e0, e1, new_e;
    logic [1:0]       occ;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [CNT_W-1:0] run, run_nxt, fa;
    logic             done_q;
    logic             push, pop;
    logic             col_end, row_end, is_last, is_anom;

    // Ready depends only on registered occupancy, never on m_ready
    assign s_ready = !rst && (occ != 2'd2);
    assign m_valid = (occ != 2'd0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign col_end = (col == CW'(IMG_W-1));
    assign row_end = (row == RW'(IMG_H-1));
    assign is_last = col_end && row_end;
    assign is_anom = |modified_pixel;
    assign run_nxt = run + CNT_W'(is_anom);

    always_comb begin
        new_e      = '0;
        new_e.pix  = is_anom ? modified_pixel : original_pixel;
        new_e.anom = is_anom;
        new_e.last = is_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0     <= '0;
            e1     <= '0;
            occ    <= 2'd0;
            col    <= '0;
            row    <= '0;
            run    <= '0;
            fa     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= push && is_last;
            if (push) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (is_last) begin
                    fa  <= run_nxt;
                    run <= '0;
                end else begin
                    run <= run_nxt;
                end
            end
            // Head entry always lives in e0; e1 only holds the second slot
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= new_e;
                    else             e1 <= new_e;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: e0 <= new_e;
                default: ;
            endcase
        end
    end

    assign m_pixel         = e0.pix;
    assign m_anomaly       = e0.anom;
    assign m_last          = e0.last;
    assign frame_done      = done_q;
    assign frame_anomalies = fa;

endmodule
